divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
Parameters: none.
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 valid  input  1  request strobe from the control FSM; accepted only in IDLE.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
REQ-006 dividend  input  32  rs1 operand; sampled at accept.
REQ-007 divisor  input  32  rs2 operand; sampled at accept.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 ready  output  1  single-cycle completion pulse; result is valid in this cycle.
REQ-010 result  output  32  quotient or remainder, registered.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 Accept: valid=1 in IDLE SHALL latch op and operands, and leave IDLE on the next edge.
REQ-013 valid while busy=1 (CALC or DONE) SHALL be ignored, with no effect on the running operation.
REQ-014 Signed ops (DIV, REM) SHALL take absolute values of both operands before iterating.
REQ-015 Unsigned ops (DIVU, REMU) SHALL use the raw operands.
REQ-016 CALC SHALL perform restoring radix-2 division, 1 quotient bit per cycle, MSB first, for exactly 32 cycles.
REQ-017 The iteration counter SHALL be 6 bits wide.
REQ-018 The partial remainder SHALL be 33 bits wide so the trial subtraction borrow is explicit.
REQ-019 After the 32nd CALC cycle the FSM SHALL enter DONE and register result.
REQ-020 Result sign fixup: DIV quotient SHALL be negated iff dividend[31]^divisor[31].
REQ-021 Result sign fixup: REM remainder SHALL be negated iff dividend[31]=1.
REQ-022 DONE SHALL last exactly one cycle with ready=1, then return to IDLE.
REQ-023 Normal latency: ready=1 in cycle 33, where the accept cycle is cycle 0.
REQ-024 Divide by zero SHALL bypass CALC and enter DONE directly, with ready=1 in cycle 1.
REQ-025 Divide by zero result: DIV/DIVU = 32'hFFFFFFFF; REM/REMU = dividend.
REQ-026 Signed overflow (DIV/REM with dividend=32'h80000000, divisor=32'hFFFFFFFF) SHALL bypass CALC, ready in cycle 1.
REQ-027 Signed overflow result: DIV = 32'h80000000; REM = 0.
REQ-028 result SHALL hold its value from DONE until the next completion or reset.
REQ-029 valid asserted in the cycle after DONE (state IDLE) SHALL be accepted normally, allowing back-to-back operations.
REQ-030 ready SHALL never be asserted without a prior accept.
REQ-031 ready SHALL be asserted exactly once per accept.

Reset
REQ-032 resetn=0 SHALL force state=IDLE, busy=0, ready=0, result=0, counter=0.
REQ-033 Reset SHALL take effect on the next clk edge, including mid-CALC and during DONE.
REQ-034 An operation aborted by reset SHALL NOT produce a ready pulse.
REQ-035 valid asserted in the same cycle as resetn=0 SHALL be ignored.

Verification
REQ-036 DIVU 100/7 -> ready in cycle 33, result=14.
REQ-037 REMU 100/7 -> ready in cycle 33, result=2.
REQ-038 DIV -7/2 -> result=32'hFFFFFFFD (-3); REM -7/2 -> result=32'hFFFFFFFF (-1).
REQ-039 DIV 5/0 -> ready in cycle 1, result=32'hFFFFFFFF; REMU 5/0 -> ready in cycle 1, result=5.
REQ-040 DIV 32'h80000000/32'hFFFFFFFF -> ready in cycle 1, result=32'h80000000; REM of the same operands -> result=0.
REQ-041 Reset and re-issue: DIVU 1000/3, resetn=0 at cycle 10 -> busy=0 and ready=0 thereafter, result=0.
REQ-042 After the REQ-041 reset, DIVU 9/3 SHALL complete in cycle 33 with result=3.
REQ-043 Ignored-request check: valid pulses during CALC SHALL leave the result and ready timing unchanged.

Source files
------------

// File: rtl/divider_unit.sv
// Purpose : iterative 32-bit integer divider (DIV, DIVU, REM, REMU) using restoring radix-2.
// Latency : ready in cycle 33 after accept; divide-by-zero and signed overflow in cycle 1.
// Backpr. : no queueing; valid is accepted only while idle, and requests seen while busy are dropped.
//
// Ports:
//   clk      - rising-edge clock
//   resetn   - synchronous active-low reset
//   valid    - request strobe, accepted only when busy=0
//   op       - 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled at accept)
//   dividend - rs1 operand (sampled at accept)
//   divisor  - rs2 operand (sampled at accept)
//   busy     - high while an operation is in flight (CALC or DONE)
//   ready    - one-cycle completion pulse, result valid in the same cycle
//   result   - registered quotient or remainder, held until the next completion
module divider_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;       // remainder carried between iterations
  logic [31:0] quo;       // shifts out dividend bits, shifts in quotient bits
  logic [31:0] dvs;       // magnitude of the divisor
  logic        want_rem;
  logic        neg_res;

  // Operand preparation at accept time
  logic        is_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        sgn_ovf;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign b_mag     = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;
  assign div_zero  = (divisor == 32'd0);
  assign sgn_ovf   = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // One restoring step. The 33-bit partial remainder makes the borrow of the
  // trial subtraction visible in bit 32: set means the divisor did not fit.
  logic [32:0] prem;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] raw_res;
  logic [31:0] fixed_res;

  always_comb begin
    prem      = {rem, quo[31]};
    diff      = prem - {1'b0, dvs};
    fits      = ~diff[32];
    rem_nxt   = fits ? diff[31:0] : prem[31:0];
    quo_nxt   = {quo[30:0], fits};
    raw_res   = want_rem ? rem_nxt : quo_nxt;
    fixed_res = neg_res ? (~raw_res + 32'd1) : raw_res;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      want_rem <= 1'b0;
      neg_res  <= 1'b0;
      ready    <= 1'b0;
      result   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (valid) begin
            cnt      <= 6'd0;
            rem      <= 32'd0;
            quo      <= a_mag;
            dvs      <= b_mag;
            want_rem <= op[1];
            // Quotient sign follows the operand sign mismatch, remainder follows the dividend.
            neg_res  <= is_signed && (op[1] ? dividend[31] : (dividend[31] ^ divisor[31]));
            if (div_zero) begin
              result <= op[1] ? dividend : 32'hFFFF_FFFF;
              ready  <= 1'b1;
              state  <= DONE;
            end else if (sgn_ovf) begin
              result <= op[1] ? 32'd0 : 32'h8000_0000;
              ready  <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            result <= fixed_res;
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Purpose : self-checking bench for divider_unit against an arithmetic reference model.
// Latency : expected completion in cycle 33 (cycle 1 for divide-by-zero / signed overflow).
// Backpr. : requests issued while busy must be dropped without disturbing the running op.
module tb_divider_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        ready;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divider_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid    (valid),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .ready    (ready),
    .result   (result)
  );

  // Reference: RISC-V M-extension division semantics written with plain operators.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (b == 32'd0)
      r = o[1] ? a : 32'hFFFF_FFFF;
    else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      r = o[1] ? 32'd0 : 32'h8000_0000;
    else begin
      case (o)
        2'd0:    r = sa / sb;
        2'd1:    r = a / b;
        2'd2:    r = sa % sb;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one request from an idle, #1-after-edge position; return the cycle
  // in which ready was seen (40 if it never came) and the result at that point.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    op = o; dividend = a; divisor = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    valid  = 1'b1;             // must be ignored while in reset
    op = 2'd1; dividend = 32'd5; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b ready=%b result=%h required 0/0/0", busy, ready, result);
    end
    valid  = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release busy=%b ready=%b required 0/0", busy, ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2};
    logic [31:0] t_a  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [8] = '{32'd7, 32'd7, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_r  [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          t_l  [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    int          lat;
    logic [31:0] res;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, res);
      n_tests++;
      if (lat != t_l[i] || res !== t_r[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] latency=%0d result=%h required latency=%0d result=%h",
                 i, lat, res, t_l[i], t_r[i]);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== t_r[i]) begin
        n_fail++;
        $display("FAIL directed_after[%0d] ready=%b busy=%b result=%h required 0/0/%h",
                 i, ready, busy, result, t_r[i]);
      end
    end
  endtask

  task automatic test_abort_reset();
    int          pulses;
    int          lat;
    logic [31:0] res;
    op = 2'd1; dividend = 32'd1000; divisor = 32'd3; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;             // asserted in cycle 10
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_reset busy=%b ready=%b result=%h required 0/0/0", busy, ready, result);
    end
    resetn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1 || busy === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_ready activity_cycles=%0d required 0", pulses);
    end
    run_op(2'd1, 32'd9, 32'd3, lat, res);
    n_tests++;
    if (lat != 33 || res !== 32'd3) begin
      n_fail++;
      $display("FAIL reissue latency=%0d result=%h required latency=33 result=00000003", lat, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_requests();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    for (int k = 0; k < 2; k++) begin
      o = k[1:0] ^ 2'd2;       // REM then REMU
      a = $urandom;
      b = $urandom_range(1, 1000);
      exp = model(o, a, b);
      op = o; dividend = a; divisor = b; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      lat = 1;
      while (ready !== 1'b1 && lat < 40) begin
        // disturb with requests (including zero divisors) during CALC
        valid    = (lat >= 3 && lat <= 20);
        op       = 2'($urandom_range(0, 3));
        dividend = $urandom;
        divisor  = (lat % 2 == 0) ? 32'd0 : $urandom;
        @(posedge clk); #1;
        lat++;
      end
      valid = 1'b0;
      n_tests++;
      if (lat != 33 || result !== exp) begin
        n_fail++;
        $display("FAIL ignored_req[%0d] latency=%0d result=%h required latency=33 result=%h",
                 k, lat, result, exp);
      end
      @(posedge clk); #1;
      n_tests++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL ignored_req_after[%0d] ready=%b busy=%b required 0/0", k, ready, busy);
      end
    end
  endtask

  // Consecutive random operations, each issued in the IDLE cycle right after DONE.
  task automatic test_random_back_to_back();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          exp_lat;
    logic [31:0] res;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      exp     = model(o, a, b);
      exp_lat = model_lat(o, a, b);
      run_op(o, a, b, lat, res);
      n_tests++;
      if (lat != exp_lat || res !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h latency=%0d result=%h required latency=%0d result=%h",
                 i, o, a, b, lat, res, exp_lat, exp);
      end
      // Now in DONE: a request here must be dropped.
      valid = 1'b1; op = 2'd1; dividend = 32'd1; divisor = 32'd0;
      @(posedge clk); #1;
      valid = 1'b0;
      n_tests++;
      if (ready !== 1'b0 || busy !== 1'b0 || result !== exp) begin
        n_fail++;
        $display("FAIL random_after[%0d] ready=%b busy=%b result=%h required 0/0/%h",
                 i, ready, busy, result, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort_reset();
    test_ignored_requests();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
